// File: rtl/tcdm_g_stream_reader_if.sv
// Bundle of the wide TCDM read ports and the outgoing data stream of the
// strided stream reader. The master side is the reader; the slave side is the memory/consumer.
interface tcdm_g_stream_reader_if #(
  parameter int ADDR_SRAM_WIDTH = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int SIZE            = 1,
  parameter int NPX             = 4
);
  localparam int BW = NPX * SIZE * DATA_WIDTH;

  logic [NPX-1:0]                 data_req_o;
  logic [NPX*ADDR_SRAM_WIDTH-1:0] data_add_o;
  logic [NPX-1:0]                 data_wen_o;
  logic [BW-1:0]                  data_wdata_o;
  logic [BW/8-1:0]                data_be_o;
  logic [BW-1:0]                  data_r_rdata_i;
  logic                           out_valid;
  logic                           out_ready;
  logic [BW-1:0]                  out_data;
  logic                           out_last;

  modport master (
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    input  data_r_rdata_i,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    output data_r_rdata_i,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/tcdm_g_stream_reader.sv
// Strided 2-D read streamer: walks rows of consecutive words separated by a stride,
// reads all NPX ports in parallel and returns the data through a 2-entry valid/ready FIFO.
module tcdm_g_stream_reader #(
  parameter int ADDR_SRAM_WIDTH = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int SIZE            = 1,
  parameter int NPX             = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic [ADDR_SRAM_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]       cfg_inner_len,
  input  logic [CNT_WIDTH-1:0]       cfg_outer_len,
  input  logic [ADDR_SRAM_WIDTH-1:0] cfg_outer_stride,
  output logic                       busy,
  output logic                       done,
  tcdm_g_stream_reader_if.master     bus
);

  localparam int BW = NPX * SIZE * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0]       CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]       CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SRAM_WIDTH-1:0] ADDR_ZERO = {ADDR_SRAM_WIDTH{1'b0}};
  localparam logic [ADDR_SRAM_WIDTH-1:0] ADDR_ONE  = {{(ADDR_SRAM_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]       inner_len_r, outer_len_r, col_r, row_r;
  logic [ADDR_SRAM_WIDTH-1:0] stride_r, addr_r, row_base_r;
  logic                       inflight_r, inflight_last_r;
  logic [BW-1:0]              fifo_data_r [2];
  logic                       fifo_last_r [2];
  logic                       wr_ptr_r, rd_ptr_r;
  logic [1:0]                 fifo_cnt_r, cnt_next_s;
  logic                       pop_s, issue_s, col_last_s, row_last_s, out_valid_s;

  // Occupancy after this cycle counts the beat already in flight, so a new request
  // is only issued when its data is guaranteed a free FIFO slot on arrival.
  assign out_valid_s = (fifo_cnt_r != 2'd0);
  assign pop_s       = out_valid_s & bus.out_ready;
  assign cnt_next_s  = fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
  assign issue_s     = (state_r == RUN) && (cnt_next_s < 2'd2);
  assign col_last_s  = (col_r == inner_len_r - CNT_ONE);
  assign row_last_s  = (row_r == outer_len_r - CNT_ONE);

  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);

  assign bus.data_req_o   = {NPX{issue_s}};
  assign bus.data_add_o   = {NPX{addr_r}};
  assign bus.data_wen_o   = {NPX{1'b1}};
  assign bus.data_wdata_o = {BW{1'b0}};
  assign bus.data_be_o    = {(BW/8){1'b1}};
  assign bus.out_valid    = out_valid_s;
  assign bus.out_data     = fifo_data_r[rd_ptr_r];
  assign bus.out_last     = out_valid_s & fifo_last_r[rd_ptr_r];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_start) begin
          if ((cfg_inner_len == CNT_ZERO) || (cfg_outer_len == CNT_ZERO)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s && col_last_s && row_last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (cnt_next_s == 2'd0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Configuration latch and 2-D address walker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_len_r <= CNT_ZERO;
      outer_len_r <= CNT_ZERO;
      stride_r    <= ADDR_ZERO;
      addr_r      <= ADDR_ZERO;
      row_base_r  <= ADDR_ZERO;
      col_r       <= CNT_ZERO;
      row_r       <= CNT_ZERO;
    end else if ((state_r == IDLE) && cfg_start) begin
      inner_len_r <= cfg_inner_len;
      outer_len_r <= cfg_outer_len;
      stride_r    <= cfg_outer_stride;
      addr_r      <= cfg_base_addr;
      row_base_r  <= cfg_base_addr;
      col_r       <= CNT_ZERO;
      row_r       <= CNT_ZERO;
    end else if (issue_s) begin
      if (col_last_s) begin
        col_r <= CNT_ZERO;
        if (!row_last_s) begin
          row_r      <= row_r + CNT_ONE;
          row_base_r <= row_base_r + stride_r;
          addr_r     <= row_base_r + stride_r;
        end
      end else begin
        col_r  <= col_r + CNT_ONE;
        addr_r <= addr_r + ADDR_ONE;
      end
    end
  end

  // In-flight tracking for the fixed one-cycle SRAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & col_last_s & row_last_s;
    end
  end

  // Two-entry output FIFO; returning read data is always accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_r[0] <= {BW{1'b0}};
      fifo_data_r[1] <= {BW{1'b0}};
      fifo_last_r[0] <= 1'b0;
      fifo_last_r[1] <= 1'b0;
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      fifo_cnt_r     <= 2'd0;
    end else begin
      if (inflight_r) begin
        fifo_data_r[wr_ptr_r] <= bus.data_r_rdata_i;
        fifo_last_r[wr_ptr_r] <= inflight_last_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      fifo_cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: tb/tb_tcdm_g_stream_reader.sv
// Randomized self-checking bench: a memory model answers the read ports and a
// pattern model (nested row/column loops) predicts addresses, beats and timing.
module tb_tcdm_g_stream_reader;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int SZ  = 1;
  localparam int NPX = 4;
  localparam int CW  = 16;
  localparam int PW  = SZ * DW;
  localparam int BW  = NPX * PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr, cfg_outer_stride;
  logic [CW-1:0] cfg_inner_len, cfg_outer_len;
  logic          busy, done;

  tcdm_g_stream_reader_if #(.ADDR_SRAM_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(SZ), .NPX(NPX)) bus ();

  tcdm_g_stream_reader #(.ADDR_SRAM_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(SZ), .NPX(NPX), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_inner_len(cfg_inner_len), .cfg_outer_len(cfg_outer_len),
    .cfg_outer_stride(cfg_outer_stride), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  logic [DW-1:0] sram [NPX][1024];

  logic [AW-1:0] addr_log[$];
  int            addr_cyc_log[$];
  logic [BW-1:0] beat_log[$];
  logic          last_log[$];
  int            beat_cyc_log[$];
  int cyc = 0, i_cnt = 0, a_cnt = 0, max_out = 0, viol = 0;
  int done_cnt = 0, done_cyc = 0, last_acc_cyc = 0, start_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  function automatic logic [BW-1:0] exp_beat(input logic [AW-1:0] a);
    logic [BW-1:0] r;
    for (int j = 0; j < NPX; j++) r[j*PW +: PW] = sram[j][a];
    return r;
  endfunction

  function automatic int bus_bad();
    logic bad;
    bad = !((bus.data_req_o == '0) || (bus.data_req_o == '1));
    for (int j = 1; j < NPX; j++)
      if (bus.data_req_o[0] && (bus.data_add_o[j*AW +: AW] !== bus.data_add_o[AW-1:0])) bad = 1'b1;
    if (bus.data_wen_o !== '1 || bus.data_wdata_o !== '0 || bus.data_be_o !== '1) bad = 1'b1;
    return bad ? 1 : 0;
  endfunction

  // Memory model: fixed one-cycle read latency, garbage when not reading
  always @(posedge clk) begin
    for (int j = 0; j < NPX; j++)
      bus.data_r_rdata_i[j*PW +: PW] <= bus.data_req_o[j] ? sram[j][bus.data_add_o[j*AW +: AW]] : DW'($urandom);
  end

  // Monitor sampling on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      i_cnt      <= a_cnt;
      prev_stall <= 1'b0;
    end else begin
      if (bus.data_req_o[0]) begin
        addr_log.push_back(bus.data_add_o[AW-1:0]);
        addr_cyc_log.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_log.push_back(bus.out_data);
        last_log.push_back(bus.out_last);
        beat_cyc_log.push_back(cyc);
        last_acc_cyc <= cyc;
      end
      i_cnt <= i_cnt + (bus.data_req_o[0] ? 1 : 0);
      a_cnt <= a_cnt + ((bus.out_valid && bus.out_ready) ? 1 : 0);
      if ((i_cnt + (bus.data_req_o[0] ? 1 : 0) - a_cnt - ((bus.out_valid && bus.out_ready) ? 1 : 0)) > max_out)
        max_out <= i_cnt + (bus.data_req_o[0] ? 1 : 0) - a_cnt - ((bus.out_valid && bus.out_ready) ? 1 : 0);
      viol <= viol + bus_bad() +
              ((prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last)) ? 1 : 0);
      prev_stall <= bus.out_valid & ~bus.out_ready;
      prev_data  <= bus.out_data;
      prev_last  <= bus.out_last;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (cfg_start && !busy) start_cyc <= cyc;
    end
  end

  // Consumer ready pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ~bus.out_ready;
        2: bus.out_ready = 1'($urandom_range(0, 1));
        3: if ((cyc - start_cyc) >= 6 && (cyc - start_cyc) < 11) bus.out_ready = 1'b0;
           else bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic run_xfer(input logic [AW-1:0] base, input int inner, input int outer,
                          input logic [AW-1:0] stride, input int mode, input bit poke, input string name);
    logic [AW-1:0] exp_addr[$];
    int a0, b0, d0, v0, n, got;
    for (int r = 0; r < outer; r++)
      for (int c = 0; c < inner; c++)
        exp_addr.push_back(AW'(int'(base) + r * int'(stride) + c));
    ready_mode = mode;
    @(posedge clk);
    #1;
    a0 = addr_log.size(); b0 = beat_log.size(); d0 = done_cnt; v0 = viol;
    cfg_base_addr = base; cfg_inner_len = CW'(inner); cfg_outer_len = CW'(outer);
    cfg_outer_stride = stride; cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy); end
    got = 0;
    for (int k = 0; k < 3000 && got == 0; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        cfg_start = poke && (k == 3);
        if (poke) begin
          cfg_base_addr = 10'h155; cfg_inner_len = 16'd1; cfg_outer_len = 16'd1;
        end
      end
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    cfg_start = 1'b0;
    checks++;
    if (got == 0) begin errors++; $display("FAIL %s done_timeout: got no done expected done", name); end
    repeat (2) @(negedge clk);
    n = addr_log.size() - a0;
    checks++;
    if (n != exp_addr.size()) begin errors++; $display("FAIL %s req_count: got %0d expected %0d", name, n, exp_addr.size()); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if (addr_log[a0+i] !== exp_addr[i]) begin
        errors++; $display("FAIL %s addr[%0d]: got %h expected %h", name, i, addr_log[a0+i], exp_addr[i]);
      end
      if (mode == 0 && i > 0) begin
        checks++;
        if (addr_cyc_log[a0+i] != addr_cyc_log[a0+i-1] + 1) begin
          errors++; $display("FAIL %s req_gap[%0d]: got %0d expected 1", name, i, addr_cyc_log[a0+i] - addr_cyc_log[a0+i-1]);
        end
      end
    end
    n = beat_log.size() - b0;
    checks++;
    if (n != exp_addr.size()) begin errors++; $display("FAIL %s beat_count: got %0d expected %0d", name, n, exp_addr.size()); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if (beat_log[b0+i] !== exp_beat(exp_addr[i]) || last_log[b0+i] !== (i == exp_addr.size() - 1)) begin
        errors++;
        $display("FAIL %s beat[%0d]: got %h last %b expected %h last %b", name, i, beat_log[b0+i],
                 last_log[b0+i], exp_beat(exp_addr[i]), (i == exp_addr.size() - 1));
      end
    end
    if (mode == 0 && n > 0 && addr_log.size() > a0) begin
      checks++;
      if (beat_cyc_log[b0] != addr_cyc_log[a0] + 2) begin
        errors++; $display("FAIL %s first_latency: got %0d expected 2", name, beat_cyc_log[b0] - addr_cyc_log[a0]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0); end
    checks++;
    if (exp_addr.size() > 0 && done_cyc != last_acc_cyc + 1) begin
      errors++; $display("FAIL %s done_timing: got cycle %0d expected %0d", name, done_cyc, last_acc_cyc + 1);
    end else if (exp_addr.size() == 0 && done_cyc != start_cyc + 1) begin
      errors++; $display("FAIL %s done_timing: got cycle %0d expected %0d", name, done_cyc, start_cyc + 1);
    end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL %s bus_protocol: got %0d violations expected 0", name, viol - v0); end
    checks++;
    if (max_out > 2) begin errors++; $display("FAIL %s buffering: got %0d outstanding expected <=2", name, max_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b expected 0", name, busy); end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.data_req_o !== '0 || bus.data_add_o !== '0 ||
        bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs: got busy %b done %b req %h add %h valid %b last %b data %h expected all 0",
               name, busy, done, bus.data_req_o, bus.data_add_o, bus.out_valid, bus.out_last, bus.out_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_row();
    run_xfer(10'h010, 4, 1, 10'h000, 0, 1'b0, "row");
  endtask

  task automatic test_2d();
    run_xfer(10'h000, 2, 3, 10'h020, 0, 1'b0, "2d");
  endtask

  task automatic test_wrap();
    run_xfer(10'h3FE, 4, 1, 10'h000, 0, 1'b0, "wrap");
    run_xfer(10'h3F0, 3, 3, 10'h300, 2, 1'b0, "wrap_stride");
  endtask

  task automatic test_backpressure();
    run_xfer(AW'($urandom), 8, 1, 10'h000, 3, 1'b0, "bp_hold");
    run_xfer(AW'($urandom), 8, 1, 10'h000, 1, 1'b0, "bp_toggle");
  endtask

  task automatic test_zero_len();
    run_xfer(10'h123, 0, 5, 10'h004, 0, 1'b0, "zero_inner");
    run_xfer(10'h123, 3, 0, 10'h004, 0, 1'b0, "zero_outer");
  endtask

  task automatic test_start_ignored();
    run_xfer(10'h200, 3, 2, 10'h010, 2, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid();
    int b0, d0, got;
    ready_mode = 0;
    @(posedge clk);
    #1;
    b0 = beat_log.size();
    cfg_base_addr = 10'h0A0; cfg_inner_len = 16'd8; cfg_outer_len = 16'd1;
    cfg_outer_stride = 10'h000; cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    got = 0;
    for (int k = 0; k < 100 && got == 0; k++) begin
      @(negedge clk);
      if (beat_log.size() - b0 >= 3) got = 1;
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL mid_reset beats_timeout: got %0d expected 3", beat_log.size() - b0); end
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset abort: got %0d done pulses busy %b expected 0 and 0", done_cnt - d0, busy);
    end
    run_xfer(10'h0A0, 8, 1, 10'h000, 0, 1'b0, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++)
      run_xfer(AW'($urandom), $urandom_range(1, 6), $urandom_range(1, 4), AW'($urandom), 2, 1'b0, "random");
  endtask

  initial begin
    for (int j = 0; j < NPX; j++)
      for (int a = 0; a < 1024; a++)
        sram[j][a] = DW'($urandom);
    cfg_start = 1'b0; cfg_base_addr = '0; cfg_inner_len = '0;
    cfg_outer_len = '0; cfg_outer_stride = '0;
    test_reset();
    test_row();
    test_2d();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
